pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 16-bit, 5-stage pipeline. It drives the enable and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Decisions come from load-use hazards, taken branches, and I-/D-cache hit status. It also keeps a saturating stall-cycle counter and a cache-miss watchdog.

Parameters:
MISS_MAX, 64, max consecutive miss cycles (I or D) before entering ERR; range 1..255
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock; controller state updates on rising edge, pipeline registers sample controls on falling edge
rst  in  1  synchronous, active-high reset
idRs  in  3  rs field of instruction in ID
idRt  in  3  rt field of instruction in ID
idUsesRt  in  1  ID instruction reads rt as a source
exMemRead  in  1  memRead of instruction in EX (ID/EX output)
exRt  in  3  destination rt of instruction in EX
branchTaken  in  1  branch resolved taken this cycle (EX/MEM branch and zero)
iHit  in  1  instruction cache hit for current fetch
dReq  in  1  MEM stage performs a load/store this cycle
dHit  in  1  data cache hit for MEM access
pcEn  out  1  PC load enable
ifidEn  out  1  IF/ID enable
ifidFlush  out  1  IF/ID load NOP
idexEn  out  1  ID/EX enable (the pipeline "hit" input)
idexBubble  out  1  ID/EX load all-zero control (bubble)
exmemEn  out  1  EX/MEM enable
exmemFlush  out  1  EX/MEM load zero control
memwbEn  out  1  MEM/WB enable
stallCnt  out  CNT_W  saturating count of cycles with pcEn=0
state  out  2  0=RUN, 1=DMISS, 2=IMISS, 3=ERR
err  out  1  sticky watchdog error

Behaviour:
- Reset, sampled at a rising edge with rst=1:
  - state=RUN, missCnt=0, stallCnt=0, err=0.
  - While rst is high, all enables are 0 and all flush/bubble outputs are 0.
  - Reset takes effect mid-miss with no residual state.
- Control outputs are combinational decode of the registered state and the current inputs. Zero latency: a hazard seen in cycle t is acted on at the falling edge of cycle t.
- loadUse = exMemRead && (exRt==idRs || (idUsesRt && exRt==idRt)). Register 0 is not exempt.
- dMiss = dReq && !dHit.
- RUN priority, highest first:
  1. dMiss
     - All enables 0; flushes 0.
     - Next state DMISS, missCnt=1.
  2. branchTaken
     - pcEn=1, all stage enables 1.
     - ifidFlush=1, idexBubble=1, exmemFlush=1.
     - Overrides loadUse and !iHit; stay RUN.
  3. loadUse
     - pcEn=0, ifidEn=0, idexEn=1, idexBubble=1, exmemEn=1, memwbEn=1.
     - Stay RUN. The hazard clears the next cycle because EX advances.
  4. !iHit
     - pcEn=0, ifidEn=0, idexEn=1, idexBubble=1, back stages enabled.
     - Next state IMISS, missCnt=1.
  5. None of the above: all enables 1, flushes 0.
- DMISS:
  - All enables 0.
  - When dHit=1: all enables 1 in that cycle, next state RUN, missCnt=0.
  - Otherwise missCnt+1. When missCnt reaches MISS_MAX with dHit still 0, next state ERR.
  - branchTaken is ignored while frozen; it is held stable by the frozen EX/MEM and re-evaluated in RUN.
- IMISS:
  - Outputs as in RUN rule 4, so back stages drain with bubbles.
  - If dMiss: DMISS rule applies and missCnt restarts at 1.
  - Else if branchTaken: RUN rule 2 outputs, next state RUN, which cancels the fetch.
  - Else if iHit: RUN rule 5 outputs, next state RUN.
  - Else missCnt+1, and ERR at MISS_MAX.
- ERR:
  - All enables 0, err=1.
  - Left only by rst.
- stallCnt increments on each rising edge where pcEn=0 (rst low) and saturates at 2^CNT_W-1.
- missCnt is 8 bits and never exceeds MISS_MAX.

Test Plan:
- Load-use: exMemRead=1, exRt=3, idRs=3 for one cycle -> pcEn=0, ifidEn=0, idexBubble=1, state stays 0, stallCnt 0->1. Same with idRt=3, idUsesRt=0, idRs=5 -> no stall.
- Branch and load-use together: branchTaken=1, loadUse=1 -> pcEn=1, ifidFlush=1, idexBubble=1, exmemFlush=1, stallCnt unchanged.
- D-miss: dReq=1, dHit=0 for 5 cycles, then dHit=1 -> state=1 for 5 cycles, all enables 0, stallCnt=5. On the hit cycle all enables are 1, and the next state is 0.
- I-miss then D-miss: iHit=0 for 3 cycles, then dReq=1, dHit=0 -> state 2 with idexBubble=1 and exmemEn=1, then state 1 with all enables 0 and missCnt=1.
- Watchdog: MISS_MAX=4, dHit stuck 0 -> state=1 for cycles 1-4, then state=3 and err=1. Stays there despite dHit=1. rst=1 for one cycle -> state=0, err=0, stallCnt=0.
- Saturation: CNT_W=4, 20 stall cycles -> stallCnt holds 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 16-bit 5-stage pipeline.
// It decodes load-use hazards, taken branches and I-/D-cache status into
// per-stage enable and bubble/flush controls. Control outputs are
// combinational from the registered state and the current inputs, so a
// hazard seen in a cycle is acted on at that cycle's falling edge, when the
// pipeline registers sample.
// It also keeps a saturating stall-cycle counter and a cache-miss watchdog
// that locks into ERR until reset.
module pipe_hazard_ctrl #(
  parameter int MISS_MAX = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       idRs,
  input  logic [2:0]       idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [2:0]       exRt,
  input  logic             branchTaken,
  input  logic             iHit,
  input  logic             dReq,
  input  logic             dHit,
  output logic             pcEn,
  output logic             ifidEn,
  output logic             ifidFlush,
  output logic             idexEn,
  output logic             idexBubble,
  output logic             exmemEn,
  output logic             exmemFlush,
  output logic             memwbEn,
  output logic [CNT_W-1:0] stallCnt,
  output logic [1:0]       state,
  output logic             err
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DMISS = 2'd1;
  localparam logic [1:0] IMISS = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  localparam logic [7:0]       MISS_LIMIT = 8'(MISS_MAX);
  localparam logic [CNT_W-1:0] STALL_SAT  = {CNT_W{1'b1}};

  logic [1:0]       stateReg;
  logic [1:0]       stateNext;
  logic [7:0]       missCntReg;
  logic [7:0]       missCntNext;
  logic [CNT_W-1:0] stallCntReg;
  logic             errReg;

  logic loadUse;
  logic dMiss;
  logic missAtLimit;

  // Register 0 is deliberately not exempt from the load-use compare.
  assign loadUse     = exMemRead && ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
  assign dMiss       = dReq && !dHit;
  assign missAtLimit = (missCntReg >= MISS_LIMIT);

  assign stallCnt = stallCntReg;
  assign state    = stateReg;
  assign err      = errReg;

  // Control decode and next-state selection per controller state.
  always_comb begin
    pcEn        = 1'b0;
    ifidEn      = 1'b0;
    ifidFlush   = 1'b0;
    idexEn      = 1'b0;
    idexBubble  = 1'b0;
    exmemEn     = 1'b0;
    exmemFlush  = 1'b0;
    memwbEn     = 1'b0;
    stateNext   = stateReg;
    missCntNext = missCntReg;

    case (stateReg)
      RUN: begin
        missCntNext = 8'd0;
        if (dMiss) begin
          // Whole pipeline freezes while the data cache refills.
          stateNext   = DMISS;
          missCntNext = 8'd1;
        end else if (branchTaken) begin
          // Redirect fetch and squash the three younger instructions;
          // this outranks both the load-use stall and an I-miss.
          pcEn       = 1'b1;
          ifidEn     = 1'b1;
          idexEn     = 1'b1;
          exmemEn    = 1'b1;
          memwbEn    = 1'b1;
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
          exmemFlush = 1'b1;
        end else if (loadUse || !iHit) begin
          // Hold PC and IF/ID, inject a bubble into EX, let the back drain.
          idexEn     = 1'b1;
          idexBubble = 1'b1;
          exmemEn    = 1'b1;
          memwbEn    = 1'b1;
          if (!loadUse) begin
            stateNext   = IMISS;
            missCntNext = 8'd1;
          end
        end else begin
          pcEn    = 1'b1;
          ifidEn  = 1'b1;
          idexEn  = 1'b1;
          exmemEn = 1'b1;
          memwbEn = 1'b1;
        end
      end

      DMISS: begin
        // A pending branch is held by the frozen EX/MEM and is picked up
        // again once back in RUN, so it is not looked at here.
        if (dHit) begin
          pcEn        = 1'b1;
          ifidEn      = 1'b1;
          idexEn      = 1'b1;
          exmemEn     = 1'b1;
          memwbEn     = 1'b1;
          stateNext   = RUN;
          missCntNext = 8'd0;
        end else if (missAtLimit) begin
          stateNext = ERR;
        end else begin
          missCntNext = missCntReg + 8'd1;
        end
      end

      IMISS: begin
        if (dMiss) begin
          // A D-miss freezes everything and restarts the watchdog.
          stateNext   = DMISS;
          missCntNext = 8'd1;
        end else if (branchTaken) begin
          // The outstanding fetch is wrong-path; abandon it.
          pcEn        = 1'b1;
          ifidEn      = 1'b1;
          idexEn      = 1'b1;
          exmemEn     = 1'b1;
          memwbEn     = 1'b1;
          ifidFlush   = 1'b1;
          idexBubble  = 1'b1;
          exmemFlush  = 1'b1;
          stateNext   = RUN;
          missCntNext = 8'd0;
        end else if (iHit) begin
          pcEn        = 1'b1;
          ifidEn      = 1'b1;
          idexEn      = 1'b1;
          exmemEn     = 1'b1;
          memwbEn     = 1'b1;
          stateNext   = RUN;
          missCntNext = 8'd0;
        end else begin
          idexEn     = 1'b1;
          idexBubble = 1'b1;
          exmemEn    = 1'b1;
          memwbEn    = 1'b1;
          if (missAtLimit) begin
            stateNext = ERR;
          end else begin
            missCntNext = missCntReg + 8'd1;
          end
        end
      end

      default: begin
        // ERR: pipeline stays frozen until reset.
        stateNext = ERR;
      end
    endcase

    // During reset the pipeline is held with no flushes asserted.
    if (rst) begin
      pcEn       = 1'b0;
      ifidEn     = 1'b0;
      ifidFlush  = 1'b0;
      idexEn     = 1'b0;
      idexBubble = 1'b0;
      exmemEn    = 1'b0;
      exmemFlush = 1'b0;
      memwbEn    = 1'b0;
    end
  end

  // Controller state and watchdog miss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= RUN;
      missCntReg <= 8'd0;
    end else begin
      stateReg   <= stateNext;
      missCntReg <= missCntNext;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntReg <= '0;
    end else if (!pcEn && (stallCntReg != STALL_SAT)) begin
      stallCntReg <= stallCntReg + CNT_W'(1);
    end
  end

  // Sticky error flag, set on the edge that enters ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      errReg <= 1'b0;
    end else begin
      errReg <= errReg | (stateNext == ERR);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: two instances (default parameters, and
// MISS_MAX=4 / CNT_W=4) share one stimulus stream and are compared against a
// behavioural model that classifies each cycle as GO / REDIRECT / DRAIN /
// FREEZE and tracks state, miss count, stall count and the error flag.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] idRs, idRt, exRt;
  logic       idUsesRt, exMemRead, branchTaken, iHit, dReq, dHit;

  logic        pcEnA, ifidEnA, ifidFlushA, idexEnA, idexBubbleA, exmemEnA, exmemFlushA, memwbEnA, errA;
  logic [15:0] stallCntA;
  logic [1:0]  stateA;
  logic        pcEnB, ifidEnB, ifidFlushB, idexEnB, idexBubbleB, exmemEnB, exmemFlushB, memwbEnB, errB;
  logic [3:0]  stallCntB;
  logic [1:0]  stateB;

  pipe_hazard_ctrl dutA (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken), .iHit(iHit),
    .dReq(dReq), .dHit(dHit), .pcEn(pcEnA), .ifidEn(ifidEnA), .ifidFlush(ifidFlushA),
    .idexEn(idexEnA), .idexBubble(idexBubbleA), .exmemEn(exmemEnA), .exmemFlush(exmemFlushA),
    .memwbEn(memwbEnA), .stallCnt(stallCntA), .state(stateA), .err(errA)
  );

  pipe_hazard_ctrl #(.MISS_MAX(4), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRt(exRt), .branchTaken(branchTaken), .iHit(iHit),
    .dReq(dReq), .dHit(dHit), .pcEn(pcEnB), .ifidEn(ifidEnB), .ifidFlush(ifidFlushB),
    .idexEn(idexEnB), .idexBubble(idexBubbleB), .exmemEn(exmemEnB), .exmemFlush(exmemFlushB),
    .memwbEn(memwbEnB), .stallCnt(stallCntB), .state(stateB), .err(errB)
  );

  // Control vector order: {pcEn, ifidEn, ifidFlush, idexEn, idexBubble, exmemEn, exmemFlush, memwbEn}
  localparam logic [7:0] CTL_GO     = 8'b1101_0101;
  localparam logic [7:0] CTL_REDIR  = 8'b1111_1111;
  localparam logic [7:0] CTL_DRAIN  = 8'b0001_1101;
  localparam logic [7:0] CTL_FREEZE = 8'b0000_0000;

  localparam int ACT_GO = 0, ACT_REDIR = 1, ACT_DRAIN = 2, ACT_FREEZE = 3;
  localparam int S_RUN = 0, S_DMISS = 1, S_IMISS = 2, S_ERR = 3;

  int missMax [2] = '{64, 4};
  int cntMax  [2] = '{65535, 15};

  typedef struct packed {
    int st;
    int miss;
    int stall;
    bit err;
  } mdl_t;

  mdl_t m [2] = '{'0, '0};

  int checks = 0;
  int errors = 0;

  logic lu, dm;
  assign lu = exMemRead && ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
  assign dm = dReq && !dHit;

  logic [7:0]  obsCtl   [2];
  logic [1:0]  obsState [2];
  logic        obsErr   [2];
  logic [15:0] obsStall [2];
  logic [26:0] obsAll   [2];
  logic [26:0] expAll   [2];

  assign obsCtl[0]   = {pcEnA, ifidEnA, ifidFlushA, idexEnA, idexBubbleA, exmemEnA, exmemFlushA, memwbEnA};
  assign obsCtl[1]   = {pcEnB, ifidEnB, ifidFlushB, idexEnB, idexBubbleB, exmemEnB, exmemFlushB, memwbEnB};
  assign obsState[0] = stateA;
  assign obsState[1] = stateB;
  assign obsErr[0]   = errA;
  assign obsErr[1]   = errB;
  assign obsStall[0] = stallCntA;
  assign obsStall[1] = {12'd0, stallCntB};
  assign obsAll[0]   = {obsCtl[0], obsState[0], obsErr[0], obsStall[0]};
  assign obsAll[1]   = {obsCtl[1], obsState[1], obsErr[1], obsStall[1]};

  // What the pipeline should do this cycle, from the hazard priority rules.
  function automatic int modelAction(input int st, input bit r, input bit luF, input bit dmF,
                                     input bit br, input bit ih, input bit dh);
    if (r) return ACT_FREEZE;
    case (st)
      S_RUN:   return dmF ? ACT_FREEZE : br ? ACT_REDIR : (luF || !ih) ? ACT_DRAIN : ACT_GO;
      S_DMISS: return dh ? ACT_GO : ACT_FREEZE;
      S_IMISS: return dmF ? ACT_FREEZE : br ? ACT_REDIR : ih ? ACT_GO : ACT_DRAIN;
      default: return ACT_FREEZE;
    endcase
  endfunction

  function automatic logic [7:0] actionCtl(input int act);
    case (act)
      ACT_GO:    return CTL_GO;
      ACT_REDIR: return CTL_REDIR;
      ACT_DRAIN: return CTL_DRAIN;
      default:   return CTL_FREEZE;
    endcase
  endfunction

  function automatic mdl_t modelNext(input mdl_t cur, input int act, input int mMax, input int cMax,
                                     input bit r, input bit dmF, input bit br, input bit luF,
                                     input bit ih, input bit dh);
    mdl_t n = cur;
    if (r) return '0;
    if ((act == ACT_FREEZE || act == ACT_DRAIN) && cur.stall < cMax) n.stall = cur.stall + 1;
    case (cur.st)
      S_RUN: begin
        n.miss = 0;
        if (dmF) begin n.st = S_DMISS; n.miss = 1; end
        else if (!br && !luF && !ih) begin n.st = S_IMISS; n.miss = 1; end
      end
      S_DMISS: begin
        if (dh) begin n.st = S_RUN; n.miss = 0; end
        else if (cur.miss >= mMax) n.st = S_ERR;
        else n.miss = cur.miss + 1;
      end
      S_IMISS: begin
        if (dmF) begin n.st = S_DMISS; n.miss = 1; end
        else if (br || ih) begin n.st = S_RUN; n.miss = 0; end
        else if (cur.miss >= mMax) n.st = S_ERR;
        else n.miss = cur.miss + 1;
      end
      default: n.st = S_ERR;
    endcase
    if (n.st == S_ERR) n.err = 1'b1;
    return n;
  endfunction

  always_comb begin
    expAll[0] = {actionCtl(modelAction(m[0].st, rst, lu, dm, branchTaken, iHit, dHit)),
                 2'(m[0].st), m[0].err, 16'(m[0].stall)};
    expAll[1] = {actionCtl(modelAction(m[1].st, rst, lu, dm, branchTaken, iHit, dHit)),
                 2'(m[1].st), m[1].err, 16'(m[1].stall)};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m[i] <= modelNext(m[i], modelAction(m[i].st, rst, lu, dm, branchTaken, iHit, dHit),
                        missMax[i], cntMax[i], rst, dm, branchTaken, lu, iHit, dHit);
    end
  end

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    rst = 1'b0; idRs = 3'd1; idRt = 3'd2; exRt = 3'd4; idUsesRt = 1'b0;
    exMemRead = 1'b0; branchTaken = 1'b0; iHit = 1'b1; dReq = 1'b0; dHit = 1'b1;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  task automatic setLoadUse();
    setIdle();
    exMemRead = 1'b1; exRt = 3'd3; idRs = 3'd3;
  endtask

  // ---------------- feature tests ----------------
  task automatic test_reset();
    setIdle();
    rst = 1'b1;
    nextCycle();
    // Drive both instances into a miss, then reset mid-miss.
    setIdle(); dReq = 1'b1; dHit = 1'b0;
    for (int c = 0; c < 6; c++) nextCycle();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      exMemRead = 1'($urandom); branchTaken = 1'($urandom); iHit = 1'($urandom);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obsCtl[i] !== CTL_FREEZE) begin
          errors++;
          $display("FAIL reset_ctl dut%0d: got %b want %b", i, obsCtl[i], CTL_FREEZE);
        end
      end
      nextCycle();
    end
    setIdle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obsState[i] !== 2'd0 || obsErr[i] !== 1'b0 || obsStall[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got state %0d err %0d stall %0d want 0 0 0",
                 i, obsState[i], obsErr[i], obsStall[i]);
      end
      checks++;
      if (obsAll[i] !== expAll[i]) begin
        errors++;
        $display("FAIL reset_model dut%0d: got %h want %h", i, obsAll[i], expAll[i]);
      end
    end
    nextCycle();
  endtask

  task automatic test_load_use();
    doReset();
    setLoadUse();
    @(negedge clk);
    checks++;
    if (obsCtl[0] !== CTL_DRAIN || obsState[0] !== 2'd0) begin
      errors++;
      $display("FAIL load_use_rs: got ctl %b state %0d want %b 0", obsCtl[0], obsState[0], CTL_DRAIN);
    end
    nextCycle();
    setIdle();
    @(negedge clk);
    checks++;
    if (obsStall[0] !== 16'd1 || obsState[0] !== 2'd0) begin
      errors++;
      $display("FAIL load_use_cnt: got stall %0d state %0d want 1 0", obsStall[0], obsState[0]);
    end
    // rt matches but instruction does not read rt: no hazard.
    exMemRead = 1'b1; exRt = 3'd3; idRt = 3'd3; idRs = 3'd5; idUsesRt = 1'b0;
    @(negedge clk);
    checks++;
    if (obsCtl[0] !== CTL_GO) begin
      errors++;
      $display("FAIL load_use_rt_unused: got %b want %b", obsCtl[0], CTL_GO);
    end
    idUsesRt = 1'b1;
    @(negedge clk);
    checks++;
    if (obsCtl[0] !== CTL_DRAIN) begin
      errors++;
      $display("FAIL load_use_rt_used: got %b want %b", obsCtl[0], CTL_DRAIN);
    end
    // Register 0 takes part in the compare like any other.
    exRt = 3'd0; idRs = 3'd0; idUsesRt = 1'b0;
    @(negedge clk);
    checks++;
    if (obsCtl[0] !== CTL_DRAIN) begin
      errors++;
      $display("FAIL load_use_r0: got %b want %b", obsCtl[0], CTL_DRAIN);
    end
    nextCycle();
  endtask

  task automatic test_branch();
    int stallBefore;
    doReset();
    setLoadUse();
    branchTaken = 1'b1; iHit = 1'b0;
    stallBefore = m[0].stall;
    @(negedge clk);
    checks++;
    if (obsCtl[0] !== CTL_REDIR) begin
      errors++;
      $display("FAIL branch_ctl: got %b want %b", obsCtl[0], CTL_REDIR);
    end
    nextCycle();
    setIdle();
    @(negedge clk);
    checks++;
    if (obsStall[0] !== 16'(stallBefore) || obsState[0] !== 2'd0) begin
      errors++;
      $display("FAIL branch_cnt: got stall %0d state %0d want %0d 0", obsStall[0], obsState[0], stallBefore);
    end
    nextCycle();
  endtask

  task automatic test_dmiss();
    doReset();
    setIdle(); dReq = 1'b1; dHit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obsAll[i] !== expAll[i]) begin
          errors++;
          $display("FAIL dmiss_cyc%0d dut%0d: got %h want %h", c, i, obsAll[i], expAll[i]);
        end
      end
      checks++;
      if (obsCtl[0] !== CTL_FREEZE || obsState[0] !== ((c == 0) ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL dmiss_freeze cyc%0d: got ctl %b state %0d", c, obsCtl[0], obsState[0]);
      end
      nextCycle();
    end
    dHit = 1'b1;
    @(negedge clk);
    checks++;
    if (obsCtl[0] !== CTL_GO || obsState[0] !== 2'd1 || obsStall[0] !== 16'd5) begin
      errors++;
      $display("FAIL dmiss_hit: got ctl %b state %0d stall %0d want %b 1 5",
               obsCtl[0], obsState[0], obsStall[0], CTL_GO);
    end
    nextCycle();
    setIdle();
    @(negedge clk);
    checks++;
    if (obsState[0] !== 2'd0 || obsStall[0] !== 16'd5) begin
      errors++;
      $display("FAIL dmiss_resume: got state %0d stall %0d want 0 5", obsState[0], obsStall[0]);
    end
    nextCycle();
  endtask

  task automatic test_imiss_dmiss();
    doReset();
    setIdle(); iHit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obsCtl[0] !== CTL_DRAIN || obsState[0] !== ((c == 0) ? 2'd0 : 2'd2)) begin
        errors++;
        $display("FAIL imiss_cyc%0d: got ctl %b state %0d want %b", c, obsCtl[0], obsState[0], CTL_DRAIN);
      end
      nextCycle();
    end
    dReq = 1'b1; dHit = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obsAll[i] !== expAll[i]) begin
          errors++;
          $display("FAIL imiss_dmiss_cyc%0d dut%0d: got %h want %h", c, i, obsAll[i], expAll[i]);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_watchdog();
    doReset();
    setIdle(); dReq = 1'b1; dHit = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c >= 6) dHit = 1'b1;
      @(negedge clk);
      checks++;
      if (obsState[1] !== ((c == 0) ? 2'd0 : (c <= 4) ? 2'd1 : 2'd3) || obsErr[1] !== (c >= 5)) begin
        errors++;
        $display("FAIL watchdog_cyc%0d: got state %0d err %0d", c, obsState[1], obsErr[1]);
      end
      checks++;
      if (obsAll[1] !== expAll[1]) begin
        errors++;
        $display("FAIL watchdog_model_cyc%0d: got %h want %h", c, obsAll[1], expAll[1]);
      end
      nextCycle();
    end
    rst = 1'b1;
    nextCycle();
    setIdle();
    @(negedge clk);
    checks++;
    if (obsState[1] !== 2'd0 || obsErr[1] !== 1'b0 || obsStall[1] !== 16'd0) begin
      errors++;
      $display("FAIL watchdog_clear: got state %0d err %0d stall %0d want 0 0 0",
               obsState[1], obsErr[1], obsStall[1]);
    end
    nextCycle();
  endtask

  task automatic test_saturation();
    doReset();
    setLoadUse();
    for (int c = 0; c < 20; c++) nextCycle();
    setIdle();
    @(negedge clk);
    checks++;
    if (obsStall[1] !== 16'd15 || obsStall[0] !== 16'd20) begin
      errors++;
      $display("FAIL saturation: got %0d/%0d want 20/15", obsStall[0], obsStall[1]);
    end
    nextCycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(63) == 0);
      idRs        = 3'($urandom_range(7));
      idRt        = 3'($urandom_range(7));
      exRt        = 3'($urandom_range(7));
      idUsesRt    = 1'($urandom);
      exMemRead   = 1'($urandom);
      branchTaken = ($urandom_range(5) == 0);
      iHit        = ($urandom_range(4) != 0);
      dReq        = ($urandom_range(4) < 2);
      dHit        = ($urandom_range(9) < 7);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obsAll[i] !== expAll[i]) begin
          errors++;
          $display("FAIL random_cyc%0d dut%0d: got %h want %h", c, i, obsAll[i], expAll[i]);
        end
      end
      nextCycle();
    end
  endtask

  initial begin
    setIdle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_dmiss();
    test_imiss_dmiss();
    test_watchdog();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
